// File: rtl/pe_mac_tile.sv
`default_nettype none
// ============================================================================
//  Module   : pe_mac_tile
//  Purpose  : Sparse multi-lane multiply-accumulate tile with a valid/ready
//             result hold. Define PE_ACC_SAT_EN for per-lane saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_mac_tile #(
    parameter int MFU_COUNT = 9,
    parameter int A_WIDTH   = 8,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 24,
    parameter int SIGNED    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [A_WIDTH-1:0]             in_act,
    input  logic [MFU_COUNT*W_WIDTH-1:0]   in_w,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MFU_COUNT*ACC_WIDTH-1:0] out_acc,
    output logic [15:0]                    out_skip,
    output logic                           out_sat
);

    localparam logic [1:0] c_ST_ACCUM = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_p_valid;
    logic        r_p_last;
    logic [15:0] r_skip;
    logic        w_accept;
    logic        w_act_nz;
    logic        w_out_fire;

    assign w_accept   = in_valid & r_in_ready;
    assign w_act_nz   = (in_act != '0);
    assign w_out_fire = r_out_valid & out_ready & (r_state == c_ST_HOLD);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_skip  = r_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_p_valid   <= 1'b0;
            r_p_last    <= 1'b0;
            r_skip      <= 16'd0;
        end else begin
            // Zero activations never reach stage 2 but still carry the tile end.
            r_p_valid <= w_accept & w_act_nz;
            r_p_last  <= w_accept & in_last;
            case (r_state)
                c_ST_ACCUM: begin
                    if (w_accept && in_last) begin
                        r_state    <= c_ST_WAIT;
                        r_in_ready <= 1'b0;
                    end
                end
                c_ST_WAIT: begin
                    if (r_p_last) begin
                        r_state     <= c_ST_HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (w_out_fire) begin
                        r_state     <= c_ST_ACCUM;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_ST_ACCUM;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
            if (w_out_fire) begin
                r_skip <= 16'd0;
            end else if (w_accept && !w_act_nz && (r_skip != 16'hFFFF)) begin
                r_skip <= r_skip + 16'd1;
            end
        end
    end

`ifdef PE_ACC_SAT_EN
    logic [MFU_COUNT-1:0] w_lane_sat;
    logic                 r_sat;

    always_ff @(posedge clk) begin
        if (rst || w_out_fire) begin
            r_sat <= 1'b0;
        end else if (r_p_valid && (|w_lane_sat)) begin
            r_sat <= 1'b1;
        end
    end
    assign out_sat = r_sat;
`else
    assign out_sat = 1'b0;
`endif

    for (genvar i = 0; i < MFU_COUNT; i++) begin : g_lane
        logic [ACC_WIDTH-1:0] w_prod;
        logic [ACC_WIDTH-1:0] w_next;
        logic [ACC_WIDTH-1:0] r_prod;
        logic [ACC_WIDTH-1:0] r_acc;

        if (SIGNED != 0) begin : g_signed
            logic signed [A_WIDTH+W_WIDTH-1:0] w_mul;
            assign w_mul  = $signed(in_act) * $signed(in_w[i*W_WIDTH +: W_WIDTH]);
            assign w_prod = ACC_WIDTH'(w_mul);
`ifdef PE_ACC_SAT_EN
            logic [ACC_WIDTH-1:0] w_sum;
            logic                 w_ovf;
            assign w_sum  = r_acc + r_prod;
            // Overflow only when both operands share a sign the result lost.
            assign w_ovf  = (r_acc[ACC_WIDTH-1] == r_prod[ACC_WIDTH-1]) &&
                            (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
            assign w_next = !w_ovf ? w_sum :
                            (r_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                : {1'b0, {(ACC_WIDTH-1){1'b1}}});
            assign w_lane_sat[i] = w_ovf;
`else
            assign w_next = r_acc + r_prod;
`endif
        end else begin : g_unsigned
            logic [A_WIDTH+W_WIDTH-1:0] w_mul;
            assign w_mul  = in_act * in_w[i*W_WIDTH +: W_WIDTH];
            assign w_prod = ACC_WIDTH'(w_mul);
`ifdef PE_ACC_SAT_EN
            logic [ACC_WIDTH-1:0] w_sum;
            logic                 w_carry;
            assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_prod};
            assign w_next = w_carry ? {ACC_WIDTH{1'b1}} : w_sum;
            assign w_lane_sat[i] = w_carry;
`else
            assign w_next = r_acc + r_prod;
`endif
        end

        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_prod <= w_prod;
            end
        end

        always_ff @(posedge clk) begin
            if (rst || w_out_fire) begin
                r_acc <= '0;
            end else if (r_p_valid) begin
                r_acc <= w_next;
            end
        end

        assign out_acc[i*ACC_WIDTH +: ACC_WIDTH] = r_acc;
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_tile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_mac_tile
//  Purpose  : Directed self-checking bench for pe_mac_tile.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_mac_tile;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_act = 8'd0;
    logic [71:0]  in_w = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [215:0] out_acc;
    logic [15:0]  out_skip;
    logic         out_sat;

    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   s_act = 8'd0;
    logic [15:0]  s_w = '0;
    logic         s_last = 1'b0;
    logic         s_out_valid;
    logic         s_out_ready = 1'b0;
    logic [31:0]  s_out_acc;
    logic [15:0]  s_out_skip;
    logic         s_out_sat;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_mac_tile dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_w(in_w), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_skip(out_skip), .out_sat(out_sat)
    );

    pe_mac_tile #(.MFU_COUNT(2), .ACC_WIDTH(16), .SIGNED(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
        .in_act(s_act), .in_w(s_w), .in_last(s_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_acc(s_out_acc),
        .out_skip(s_out_skip), .out_sat(s_out_sat)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return {8'd0, out_acc[i*24 +: 24]};
    endfunction

    // Called at a negedge; presents one beat and returns at the next negedge.
    task automatic send(input logic [7:0] act, input logic [71:0] w, input logic last);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_val("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_act   = act;
        in_w     = w;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_val("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [71:0]       w;
        logic [215:0]      snap_acc;
        logic [15:0]       snap_skip;
        logic              stable;
        logic [7:0]        act;
        logic signed [7:0] sa;
        logic signed [7:0] sw;
        int                exp_acc [9];
        int                exp_skip;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_skip", {16'd0, out_skip}, 32'd0);
        check_val("rst_out_sat", {31'd0, out_sat}, 32'd0);
        check_val("rst_lane0", lane(0), 32'd0);

        // Tile 1: act 2,3,-1; lane0 weight 1, others 4.
        w = {8{8'd4}};
        w = {w[63:0], 8'd1};
        send(8'd2, w, 1'b0);
        send(8'd3, w, 1'b0);
        send(8'hFF, w, 1'b1);
        check_val("lat_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_val("lat_valid", {31'd0, out_valid}, 32'd1);
        check_val("t1_lane0", lane(0), 32'd4);
        for (int i = 1; i < 9; i++) check_val("t1_lane", lane(i), 32'd16);
        check_val("t1_skip", {16'd0, out_skip}, 32'd0);

        // Hold with out_ready low.
        snap_acc  = out_acc;
        snap_skip = out_skip;
        stable    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_acc !== snap_acc || out_skip !== snap_skip || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        check_val("hold_stable", {31'd0, stable}, 32'd1);
        check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
        release_result();
        check_val("rel_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rel_lane0", lane(0), 32'd0);

        // Tile 2: act 0,5,0,0 weights 7.
        w = {9{8'd7}};
        send(8'd0, w, 1'b0);
        send(8'd5, w, 1'b0);
        send(8'd0, w, 1'b0);
        send(8'd0, w, 1'b1);
        wait_result();
        for (int i = 0; i < 9; i++) check_val("t2_lane", lane(i), 32'd35);
        check_val("t2_skip", {16'd0, out_skip}, 32'd3);
        release_result();

        // Tile 3: single zero activation.
        send(8'd0, {9{8'd55}}, 1'b1);
        wait_result();
        for (int i = 0; i < 9; i++) check_val("t3_lane", lane(i), 32'd0);
        check_val("t3_skip", {16'd0, out_skip}, 32'd1);
        release_result();

        // Back-to-back tiles with random gaps against a reference sum.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 9; i++) exp_acc[i] = 0;
            exp_skip = 0;
            for (int b = 0; b < 5; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                act = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom);
                if (act == 8'd0) exp_skip++;
                else begin
                    sa = act;
                    for (int i = 0; i < 9; i++) begin
                        sw = w[i*8 +: 8];
                        exp_acc[i] += int'(sa) * int'(sw);
                    end
                end
                send(act, w, (b == 4));
            end
            wait_result();
            for (int i = 0; i < 9; i++)
                check_val("rand_lane", lane(i), {8'd0, exp_acc[i][23:0]});
            check_val("rand_skip", {16'd0, out_skip}, exp_skip);
            release_result();
        end

        // 16-bit accumulator overflow: 3 x (127*127) = 48387.
        for (int b = 0; b < 3; b++) begin
            s_valid = 1'b1;
            s_act   = 8'd127;
            s_w     = {2{8'd127}};
            s_last  = (b == 2);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        begin
            int t = 0;
            while (!s_out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check_val("ovf_timeout", 32'd0, 32'd1);
        end
`ifdef PE_ACC_SAT_EN
        check_val("ovf_lane0", {16'd0, s_out_acc[15:0]}, 32'd32767);
        check_val("ovf_lane1", {16'd0, s_out_acc[31:16]}, 32'd32767);
        check_val("ovf_sat", {31'd0, s_out_sat}, 32'd1);
`else
        check_val("ovf_lane0", {16'd0, s_out_acc[15:0]}, 32'd48387);
        check_val("ovf_lane1", {16'd0, s_out_acc[31:16]}, 32'd48387);
        check_val("ovf_sat", {31'd0, s_out_sat}, 32'd0);
`endif
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;

        // Reset mid-tile, then a fresh single-beat tile.
        send(8'd0, {9{8'd5}}, 1'b0);
        send(8'd3, {9{8'd5}}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_skip", {16'd0, out_skip}, 32'd0);
        send(8'd1, {9{8'd9}}, 1'b1);
        wait_result();
        for (int i = 0; i < 9; i++) check_val("mid_rst_lane", lane(i), 32'd9);
        check_val("mid_rst_tile_skip", {16'd0, out_skip}, 32'd0);
        release_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_mac_tile.md
Name: pe_mac_tile

Overview:
Sequential successor to the combinational 3x3 PE. Each accepted beat carries one activation, broadcast to all MFU lanes, plus one weight per lane. Each lane multiplies and accumulates into its own accumulator over a tile of beats, skipping zero activations (sparse). At tile end the lane sums are held on a valid/ready output until consumed. Sits between the activation/weight feeders and the output/partial-sum buffer.

Parameters:
MFU_COUNT, 9, number of multiply-accumulate lanes
A_WIDTH, 8, activation width
W_WIDTH, 8, per-lane weight width
ACC_WIDTH, 24, per-lane accumulator width; must be >= A_WIDTH+W_WIDTH
SIGNED, 1, 1 = two's-complement operands and accumulators; 0 = unsigned

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  PE can accept a beat
in_act  input  A_WIDTH  activation shared by all lanes
in_w  input  MFU_COUNT*W_WIDTH  lane i weight at [i*W_WIDTH +: W_WIDTH]
in_last  input  1  beat is the last of the tile
out_valid  output  1  tile result valid
out_ready  input  1  consumer accepts result
out_acc  output  MFU_COUNT*ACC_WIDTH  lane i sum at [i*ACC_WIDTH +: ACC_WIDTH]
out_skip  output  16  zero activations skipped in this tile
out_sat  output  1  some lane saturated in this tile; tied 0 when PE_ACC_SAT_EN is undefined

Behaviour:
- Reset (rst=1 at an edge): state=ACCUM, accumulators=0, pipeline valid=0, out_valid=0, out_skip=0, out_sat=0. in_ready is 1 after reset. Reset mid-tile discards all partial state.
- Beat accepted at edge k when in_valid & in_ready.
- Stage 1 (edge k): register the MFU_COUNT products, sign- or zero-extended to ACC_WIDTH according to SIGNED, plus p_valid and p_last.
- Zero skip: if in_act==0, p_valid=0 (no accumulate) and the skip counter increments. The counter saturates at 16'hFFFF. p_last still propagates.
- Stage 2 (edge k+1): if p_valid, each acc[i] <= acc[i] + prod[i]. Without the macro, results wrap modulo 2^ACC_WIDTH.
- If p_last is set at edge k+1, out_valid=1 at edge k+1. out_acc and out_skip then reflect the whole tile. Latency from last beat to out_valid is 2 edges.
- FSM:
  - ACCUM: in_ready=1. Accepting a beat with in_last=1 moves to WAIT.
  - WAIT: in_ready=0. Stage 2 completes and out_valid rises, then move to HOLD.
  - HOLD: in_ready=0. out_acc, out_skip and out_sat are stable while out_valid=1 and out_ready=0. On out_valid & out_ready: clear accumulators, out_skip and out_sat; out_valid=0; return to ACCUM. in_ready is 1 in the next cycle (no bypass).
- out_ready high before out_valid has no effect.
- A one-beat tile (in_last on the first beat) is legal. A tile consisting only of zero activations is legal: out_acc=0, out_skip=beat count.
- in_w is ignored on zero-activation beats.
- All outputs are registered. No combinational path from in_* to out_*, or from out_ready to in_ready.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- When defined, stage-2 addition saturates per lane:
  - SIGNED=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SIGNED=0: clamp to [0, 2^ACC_WIDTH-1].
  - out_sat becomes sticky-high for the tile when any lane clamps.
- When undefined: accumulation wraps, no saturation logic is built, out_sat is constant 0.

Test Plan:
- Reset then 3-beat tile, SIGNED=1, act=2,3,-1, all weights 4 (lane 0 weight 1) -> out_valid 2 cycles after last beat; lanes 1..8=16, lane0=4; out_skip=0.
- Tile act=0,5,0,0 last, weights all 7 -> all lanes 35, out_skip=3; a tile of act=0 only -> all lanes 0, out_skip=1.
- Hold out_ready=0 for 10 cycles after out_valid -> in_ready=0, outputs stable. out_ready=1 -> next cycle out_valid=0, in_ready=1, next tile starts from 0.
- Random in_valid gaps plus back-to-back tiles, compared against a reference model -> sums match, no beat lost or double-counted.
- ACC_WIDTH=16, SIGNED=1, act=127, w=127, 3 beats (sum 48387): without macro out_acc=48387-65536=-17149, out_sat=0; with PE_ACC_SAT_EN out_acc=32767, out_sat=1.
- Assert rst mid-tile after 2 beats, then a fresh 1-beat tile act=1,w=9 -> out_acc lanes=9, out_skip=0.
